// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, error codes and default SOF
// shared by the UART RX framer slice.
package uart_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] err_t;

  localparam state_t ST_HUNT = 2'd0;
  localparam state_t ST_LEN  = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_CHK  = 2'd3;

  localparam err_t ERR_NONE = 2'b00;
  localparam err_t ERR_LEN  = 2'b01;
  localparam err_t ERR_CHK  = 2'b10;
  localparam err_t ERR_TMO  = 2'b11;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if: RX FIFO pop side, payload
// valid/ready side and frame status of the framer.
interface uart_rx_framer_if
  import uart_pkg::*;
#(
  parameter int D_W = 8
);
  logic           ff_empty;
  logic [D_W-1:0] ff_data_out;
  logic           ff_rd_en;
  logic [D_W-1:0] pl_data;
  logic           pl_valid;
  logic           pl_ready;
  logic           pl_last;
  logic           frm_done;
  logic           frm_err;
  err_t           err_code;

  modport master (
    input  ff_empty, ff_data_out, pl_ready,
    output ff_rd_en, pl_data, pl_valid,
    output pl_last, frm_done, frm_err,
    output err_code
  );

  modport slave (
    output ff_empty, ff_data_out, pl_ready,
    input  ff_rd_en, pl_data, pl_valid,
    input  pl_last, frm_done, frm_err,
    input  err_code
  );
endinterface

// File: rtl/uart_frm_timer.sv
// uart_frm_timer: inter-byte timeout counter, built
// only with UART_RX_FRAMER_TIMEOUT_EN.
module uart_frm_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  assign expired = en && !clr &&
    (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TW'(1);
    end
  end
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: SOF/LEN/payload/CHK framer on an RX FIFO.
// Macro UART_RX_FRAMER_TIMEOUT_EN adds an inter-byte timeout.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int             D_W     = 8,
  parameter int             MAX_LEN = 16,
  parameter logic [D_W-1:0] SOF     = SOF_DEFAULT,
  parameter int             TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ff_empty,
  input  logic [D_W-1:0] ff_data_out,
  output logic           ff_rd_en,
  output logic [D_W-1:0] pl_data,
  output logic           pl_valid,
  input  logic           pl_ready,
  output logic           pl_last,
  output logic           frm_done,
  output logic           frm_err,
  output err_t           err_code
);
  localparam int CW = $clog2(MAX_LEN + 1);

  state_t         state;
  logic           eval;
  logic [CW-1:0]  rem;
  logic [D_W-1:0] acc;
  logic           tmo;
  logic           len_bad;

  assign len_bad = (ff_data_out == '0) ||
    (int'(ff_data_out) > MAX_LEN);

`ifdef UART_RX_FRAMER_TIMEOUT_EN
  uart_frm_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (ff_rd_en || state == ST_HUNT),
    .en     (state != ST_HUNT && !pl_valid),
    .expired(tmo)
  );
`else
  // no timer: a stalled frame waits forever
  assign tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_HUNT;
      eval     <= 1'b0;
      ff_rd_en <= 1'b0;
      rem      <= '0;
      acc      <= '0;
      pl_data  <= '0;
      pl_valid <= 1'b0;
      pl_last  <= 1'b0;
      frm_done <= 1'b0;
      frm_err  <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      frm_done <= 1'b0;
      frm_err  <= 1'b0;
      eval     <= ff_rd_en;
      // one pop in flight, none while a byte waits
      ff_rd_en <= !ff_empty && !ff_rd_en &&
        !eval && !pl_valid;
      if (pl_valid && pl_ready) begin
        pl_valid <= 1'b0;
        pl_last  <= 1'b0;
        if (pl_last) state <= ST_CHK;
      end
      if (eval) begin
        unique case (1'b1)
          state == ST_HUNT: begin
            if (ff_data_out == SOF) state <= ST_LEN;
          end
          state == ST_LEN: begin
            if (len_bad) begin
              frm_err  <= 1'b1;
              err_code <= ERR_LEN;
              state    <= ST_HUNT;
            end else begin
              rem   <= CW'(ff_data_out);
              acc   <= ff_data_out;
              state <= ST_DATA;
            end
          end
          state == ST_DATA: begin
            pl_data  <= ff_data_out;
            pl_valid <= 1'b1;
            pl_last  <= (rem == CW'(1));
            acc      <= acc ^ ff_data_out;
            rem      <= rem - CW'(1);
          end
          state == ST_CHK: begin
            if (ff_data_out == acc) begin
              frm_done <= 1'b1;
            end else begin
              frm_err  <= 1'b1;
              err_code <= ERR_CHK;
            end
            state <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end else if (tmo) begin
        frm_err  <= 1'b1;
        err_code <= ERR_TMO;
        state    <= ST_HUNT;
      end
    end
  end
endmodule
